gshare_predictor: RTL and testbench
===================================

# gshare_predictor

Parametrised global-history branch predictor for the RISC-V fetch stage: a global history register (GHR) plus a pattern history table (PHT) of 2-bit saturating counters. Fetch gets a taken/not-taken prediction each cycle. Execute later reports the resolved outcome, which trains the PHT and, on a mispredict, repairs the GHR from a checkpoint. It supersedes the plain history-shift-register block and drives the PHT index internally.

## Interface
- HIST_W, 10: GHR width; the PHT has 2**HIST_W entries.
- INDEX_MODE, 1: 0 = index is GHR only; 1 = gshare, index = GHR ^ lookup_pc[HIST_W+1:2].
- RESET_HIST, all ones: GHR value loaded at reset and at the end of the init sweep.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- lookup_valid  in  1  fetch presents an instruction this cycle.
- lookup_pc  in  32  PC of the fetched instruction.
- lookup_inst  in  32  fetched instruction word.
- pred_taken  out  1  prediction for the current lookup (combinational).
- pred_idx  out  HIST_W  PHT index used for the current lookup.
- pred_hist  out  HIST_W  GHR value before this lookup's update (checkpoint).
- resolve_valid  in  1  execute reports one resolved conditional branch.
- resolve_idx  in  HIST_W  pred_idx carried down the pipe with that branch.
- resolve_hist  in  HIST_W  pred_hist carried down the pipe with that branch.
- resolve_taken  in  1  actual outcome of the branch.
- resolve_mispredict  in  1  the actual outcome differed from the prediction.
- ready  out  1  init sweep finished; predictions are valid.

## Operation
- Branch detection: a lookup is a branch when lookup_valid=1, ready=1 and lookup_inst[6:0]==7'b1100011.
- States:
  - INIT, entered on reset: a sweep counter writes 2'b01 (weakly not-taken) to one PHT entry per cycle, from index 0 to 2**HIST_W-1.
  - When the last entry has been written, the block moves to RUN and loads RESET_HIST into the GHR.
  - In INIT: ready=0, pred_taken=0, lookups and resolves are ignored, GHR is held.
- Prediction (RUN): pred_taken = PHT[pred_idx][1].
  - pred_idx follows INDEX_MODE.
  - pred_hist = current GHR.
  - All three outputs are valid whenever lookup_valid=1.
- Speculative history update: on a branch lookup, GHR <= {GHR[HIST_W-2:0], pred_taken}. Non-branch lookups leave GHR unchanged.
- Training: on resolve_valid, PHT[resolve_idx] moves toward resolve_taken.
  - Taken: +1, saturating at 2'b11.
  - Not taken: -1, saturating at 2'b00.
- Recovery: on resolve_valid with resolve_mispredict=1, GHR <= {resolve_hist[HIST_W-2:0], resolve_taken}.
- Priority in one cycle: recovery overrides the speculative shift, so a same-cycle branch lookup does not shift the GHR. The lookup's prediction is still produced from the pre-edge state.
- Same-index lookup and resolve in one cycle: the lookup reads the old counter value (read-before-write).
- resolve_mispredict with resolve_valid=0 is ignored.

## Timing
- Reset: when rst_n=0 at a rising edge:
  - state <= INIT, sweep counter <= 0, GHR <= RESET_HIST.
  - Outputs: ready=0, pred_taken=0, pred_idx=0, pred_hist=RESET_HIST.
- Init duration: ready rises exactly 2**HIST_W cycles after the first edge with rst_n=1.
- Reset asserted mid-sweep or in RUN restarts the sweep from index 0. The PHT is fully re-initialised.
- Prediction latency: 0 cycles (combinational from lookup_pc and state).
- GHR and PHT updates are visible on the cycle after the edge that commits them.
- At most one lookup and one resolve per cycle.
- Index wrap: the gshare XOR is truncated to HIST_W bits. The sweep counter must terminate at the last index and must not wrap to 0.

## Test plan
- Reset/init, HIST_W=4:
  - Stimulus: hold rst_n=0 for 2 cycles, then release.
  - Required: ready=0 for exactly 16 cycles, then 1.
  - Required: GHR=4'b1111, and every PHT index predicts not-taken.
- Speculative shift, HIST_W=4, INDEX_MODE=0, after init:
  - Stimulus: three branch lookups (inst opcode 1100011) in consecutive cycles, all predicted 0.
  - Required: pred_hist reads 1111, 1110, 1100.
  - Required: a non-branch lookup (opcode 0110011) leaves pred_hist at 1000.
- Training saturation:
  - Stimulus: four resolves, taken=1, idx=5.
  - Required: counter goes 01->10->11->11; a lookup at idx 5 predicts 1.
  - Stimulus: then three resolves, taken=0, idx=5.
  - Required: counter goes 11->10->01->00.
- Mispredict recovery with collision:
  - Stimulus: resolve_valid=1, mispredict=1, hist=4'b0101, taken=1, in the same cycle as a branch lookup.
  - Required: next-cycle GHR=4'b1011; the lookup's shift is discarded.
- Gshare index, HIST_W=4, INDEX_MODE=1:
  - Stimulus: GHR=4'b1111, lookup_pc=32'h0000_0014.
  - Required: pred_idx=4'b1010.
- Mid-run reset:
  - Stimulus: train idx 3 to 11, then pulse rst_n low for 1 cycle.
  - Required: ready drops, 16 sweep cycles follow, and idx 3 then predicts 0.

Source files
------------

// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - gshare branch predictor: GHR plus PHT of 2-bit saturating counters
module gshare_predictor #(
    parameter int                HIST_W     = 10,
    parameter int                INDEX_MODE = 1,
    parameter logic [HIST_W-1:0] RESET_HIST = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_valid,
    input  logic [31:0]       lookup_pc,
    input  logic [31:0]       lookup_inst,
    output logic              pred_taken,
    output logic [HIST_W-1:0] pred_idx,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              resolve_valid,
    input  logic [HIST_W-1:0] resolve_idx,
    input  logic [HIST_W-1:0] resolve_hist,
    input  logic              resolve_taken,
    input  logic              resolve_mispredict,
    output logic              ready
);

    localparam int                PHT_N    = 1 << HIST_W;
    localparam logic [HIST_W-1:0] LAST_IDX = '1;
    localparam logic [6:0]        OP_BRANCH = 7'b1100011;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [HIST_W-1:0] sweep_cnt;
    logic [HIST_W-1:0] ghr;
    logic [HIST_W-1:0] ghr_next;
    logic [HIST_W-1:0] lookup_idx;
    logic              is_branch;
    logic              sweep_done;
    logic [1:0]        pht [PHT_N];

    // Inputs only partly consumed depending on HIST_W / INDEX_MODE.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, lookup_pc, lookup_inst[31:7], resolve_hist[HIST_W-1]};

    generate
        if (INDEX_MODE != 0) begin : g_gshare
            assign lookup_idx = ghr ^ lookup_pc[HIST_W+1:2];
        end else begin : g_global
            assign lookup_idx = ghr;
        end
    endgenerate

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        res = cnt;
        if (taken && cnt != 2'b11) begin
            res = cnt + 2'b01;
        end else if (!taken && cnt != 2'b00) begin
            res = cnt - 2'b01;
        end
        return res;
    endfunction

    always_comb begin
        ready      = (state == ST_RUN);
        pred_idx   = ready ? lookup_idx : '0;
        pred_taken = ready & pht[pred_idx][1];
        pred_hist  = ghr;
        is_branch  = lookup_valid & ready & (lookup_inst[6:0] == OP_BRANCH);
        sweep_done = (state == ST_INIT) && (sweep_cnt == LAST_IDX);
    end

    always_comb begin
        state_next = state;
        ghr_next   = ghr;
        case (state)
            ST_INIT: begin
                if (sweep_done) begin
                    state_next = ST_RUN;
                    ghr_next   = RESET_HIST;
                end
            end
            ST_RUN: begin
                // Recovery wins over the speculative shift of a same-cycle branch.
                if (resolve_valid && resolve_mispredict) begin
                    ghr_next = {resolve_hist[HIST_W-2:0], resolve_taken};
                end else if (is_branch) begin
                    ghr_next = {ghr[HIST_W-2:0], pred_taken};
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            sweep_cnt <= '0;
            ghr       <= RESET_HIST;
        end else begin
            state <= state_next;
            ghr   <= ghr_next;
            if (state == ST_INIT && !sweep_done) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end
        end
    end

    // Table has no reset; the init sweep rewrites every entry after each reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == ST_INIT) begin
                pht[sweep_cnt] <= 2'b01;
            end else if (resolve_valid) begin
                pht[resolve_idx] <= sat_update(pht[resolve_idx], resolve_taken);
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - randomized and directed checks of gshare_predictor against a reference model
module tb_gshare_predictor;

    localparam int HIST_W = 4;
    localparam int N      = 1 << HIST_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              lookup_valid;
    logic [31:0]       lookup_pc;
    logic [31:0]       lookup_inst;
    logic              pred_taken;
    logic [HIST_W-1:0] pred_idx;
    logic [HIST_W-1:0] pred_hist;
    logic              resolve_valid;
    logic [HIST_W-1:0] resolve_idx;
    logic [HIST_W-1:0] resolve_hist;
    logic              resolve_taken;
    logic              resolve_mispredict;
    logic              ready;

    gshare_predictor #(.HIST_W(HIST_W), .INDEX_MODE(1), .RESET_HIST(4'b1111)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .lookup_valid       (lookup_valid),
        .lookup_pc          (lookup_pc),
        .lookup_inst        (lookup_inst),
        .pred_taken         (pred_taken),
        .pred_idx           (pred_idx),
        .pred_hist          (pred_hist),
        .resolve_valid      (resolve_valid),
        .resolve_idx        (resolve_idx),
        .resolve_hist       (resolve_hist),
        .resolve_taken      (resolve_taken),
        .resolve_mispredict (resolve_mispredict),
        .ready              (ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int ref_pht [N];
    int ref_ghr;
    bit ref_run;
    int ref_cnt;

    logic              s_ready;
    logic              s_taken;
    logic [HIST_W-1:0] s_idx;
    logic [HIST_W-1:0] s_hist;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        lookup_valid       = 1'b0;
        lookup_pc          = 32'h0;
        lookup_inst        = 32'h0000_0033;
        resolve_valid      = 1'b0;
        resolve_idx        = '0;
        resolve_hist       = '0;
        resolve_taken      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input bit branch);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        lookup_inst  = branch ? 32'h0000_0063 : 32'h0000_0033;
    endtask

    task automatic resolve(input int idx, input int hist, input bit taken, input bit mis);
        resolve_valid      = 1'b1;
        resolve_idx        = HIST_W'(idx);
        resolve_hist       = HIST_W'(hist);
        resolve_taken      = taken;
        resolve_mispredict = mis;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model across the edge.
    task automatic step();
        int  idx;
        int  exp_taken;
        bit  branch;
        @(negedge clk);
        s_ready = ready;
        s_taken = pred_taken;
        s_idx   = pred_idx;
        s_hist  = pred_hist;
        idx       = ref_run ? ((ref_ghr ^ int'(lookup_pc >> 2)) % N) : 0;
        exp_taken = ref_run ? int'(ref_pht[idx] >= 2) : 0;
        check("ready", 32'(s_ready), 32'(ref_run));
        check("pred_idx", 32'(s_idx), 32'(idx));
        check("pred_taken", 32'(s_taken), 32'(exp_taken));
        check("pred_hist", 32'(s_hist), 32'(ref_ghr));
        if (!rst_n) begin
            ref_run = 0;
            ref_cnt = 0;
            ref_ghr = N - 1;
        end else if (!ref_run) begin
            ref_cnt++;
            if (ref_cnt == N) begin
                ref_run = 1;
                ref_ghr = N - 1;
                foreach (ref_pht[i]) ref_pht[i] = 1;
            end
        end else begin
            branch = lookup_valid && (lookup_inst[6:0] == 7'b1100011);
            if (resolve_valid) begin
                if (resolve_taken) ref_pht[resolve_idx] = (ref_pht[resolve_idx] == 3) ? 3 : ref_pht[resolve_idx] + 1;
                else               ref_pht[resolve_idx] = (ref_pht[resolve_idx] == 0) ? 0 : ref_pht[resolve_idx] - 1;
            end
            if (resolve_valid && resolve_mispredict)
                ref_ghr = (int'(resolve_hist) * 2 + int'(resolve_taken)) % N;
            else if (branch)
                ref_ghr = (ref_ghr * 2 + exp_taken) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic count_init(input string tag);
        int zeros;
        int guard;
        zeros = 0;
        guard = 0;
        do begin
            step();
            if (!s_ready) zeros++;
            guard++;
        end while (!s_ready && guard < 40);
        check(tag, 32'(zeros), 32'(N));
    endtask

    initial begin
        bit exp_seq [4];
        logic [31:0] tmp;
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        ref_run = 0;
        ref_cnt = 0;
        ref_ghr = N - 1;
        foreach (ref_pht[i]) ref_pht[i] = 1;

        // Reset held, then init sweep length
        step();
        step();
        check("reset_hist", 32'(s_hist), 32'hF);
        rst_n = 1'b1;
        count_init("init_len");
        check("ghr_after_init", 32'(s_hist), 32'hF);

        // Every index weakly not-taken
        for (int p = 0; p < N; p++) begin
            lookup(32'(p * 4), 1'b0);
            step();
            check("init_pred", 32'(s_taken), 32'h0);
        end

        // Speculative shift
        exp_seq = '{1'b0, 1'b0, 1'b0, 1'b0};
        lookup(32'h0, 1'b1); step(); check("shift0", 32'(s_hist), 32'hF);
        lookup(32'h0, 1'b1); step(); check("shift1", 32'(s_hist), 32'hE);
        lookup(32'h0, 1'b1); step(); check("shift2", 32'(s_hist), 32'hC);
        lookup(32'h0, 1'b0); step(); check("nonbranch", 32'(s_hist), 32'h8);
        lookup(32'h0, 1'b0); step(); check("nonbranch_hold", 32'(s_hist), 32'h8);

        // Saturating training at idx 5 (GHR=1000, pc[5:2]=1101)
        exp_seq = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            lookup(32'h34, 1'b0);
            resolve(5, 0, 1'b1, 1'b0);
            step();
            check("train_up", 32'(s_taken), 32'(exp_seq[k]));
        end
        idle(); lookup(32'h34, 1'b0); step(); check("sat_hi", 32'(s_taken), 32'h1);
        exp_seq = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 3; k++) begin
            lookup(32'h34, 1'b0);
            resolve(5, 0, 1'b0, 1'b0);
            step();
            check("train_dn", 32'(s_taken), 32'(exp_seq[k]));
        end
        idle(); lookup(32'h34, 1'b0); step(); check("at_00", 32'(s_taken), 32'h0);
        lookup(32'h34, 1'b0); resolve(5, 0, 1'b1, 1'b0); step();
        idle(); lookup(32'h34, 1'b0); step(); check("from_00", 32'(s_taken), 32'h0);

        // Recovery collides with a branch lookup
        lookup(32'h0, 1'b1); resolve(0, 4'b0101, 1'b1, 1'b1); step();
        idle(); lookup(32'h0, 1'b0); step(); check("recover", 32'(s_hist), 32'hB);

        // Gshare index
        idle(); resolve(0, 4'b0111, 1'b1, 1'b1); step();
        idle(); lookup(32'h14, 1'b0); step(); check("gshare_idx", 32'(s_idx), 32'hA);

        // Mid-run reset wipes trained entry 3
        idle(); resolve(3, 0, 1'b1, 1'b0); step();
        resolve(3, 0, 1'b1, 1'b0); step();
        idle(); lookup(32'h30, 1'b0); step(); check("idx3_trained", 32'(s_taken), 32'h1);
        idle(); rst_n = 1'b0; step();
        rst_n = 1'b1;
        count_init("reinit_len");
        idle(); lookup(32'h30, 1'b0); step(); check("idx3_cleared", 32'(s_taken), 32'h0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n        = ($urandom_range(0, 399) != 0);
            lookup_valid = 1'($urandom_range(0, 1));
            lookup_pc    = $urandom;
            tmp          = $urandom;
            if ($urandom_range(0, 1) == 1) tmp[6:0] = 7'b1100011;
            lookup_inst        = tmp;
            resolve_valid      = 1'($urandom_range(0, 1));
            resolve_idx        = HIST_W'($urandom_range(0, N - 1));
            resolve_hist       = HIST_W'($urandom_range(0, N - 1));
            resolve_taken      = 1'($urandom_range(0, 1));
            resolve_mispredict = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
